// File: rtl/switch_input_conditioner_pkg.sv
// Shared types for the switch input front end.
// State encoding and debounce defaults.
package IO_UnitTypes;

  typedef enum logic {
    SCS_INIT = 1'b0,
    SCS_RUN  = 1'b1
  } SwitchCondState;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1 << 16;
  localparam int DEBOUNCE_COUNT_WIDTH =
    $clog2(DEBOUNCE_CYCLES_DEFAULT);

  typedef logic [DEBOUNCE_COUNT_WIDTH-1:0] DebounceCountPath;

endpackage

// File: rtl/switch_input_conditioner_debounce_bit.sv
// One switch bit: synchroniser chain, debounce counter
// and stable flop with a look-ahead flip strobe.
module switch_debounce_bit
  import IO_UnitTypes::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic negResetIn,
  input  logic init,
  input  logic in,
  output logic stable,
  output logic flip
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   stable_q;
  logic                   synced;
  logic                   differ;

  assign synced = sync_q[SYNC_STAGES-1];
  assign differ = synced != stable_q;
  assign stable = stable_q;
  // High on the cycle whose closing edge flips stable.
  assign flip   = ~init & differ & (cnt_q == LAST);

  always_ff @(posedge clk or negedge negResetIn) begin
    if (!negResetIn) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      if (init) begin
        stable_q <= synced;
        cnt_q    <= '0;
      end else if (!differ) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        stable_q <= synced;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_input_conditioner.sv
// Debounced slide/push switch front end: gaze vector,
// gaze-change strobe and approximation-level press capture.
module switch_input_conditioner
  import IO_UnitTypes::*;
#(
  parameter int SW_WIDTH        = 16,
  parameter int PSW_WIDTH       = 8,
  parameter int AX_LEVEL_WIDTH  = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                      clk,
  input  logic                      negResetIn,
  input  logic [SW_WIDTH-1:0]       swIn,
  input  logic [PSW_WIDTH-1:0]      pswIn,
  output logic [SW_WIDTH-1:0]       gazeOut,
  output logic                      gazeChanged,
  output logic                      axLevelEn,
  output logic [AX_LEVEL_WIDTH-1:0] axLevelData,
  output logic                      initDone
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] INIT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  SwitchCondState              state_q;
  logic [CW-1:0]               initCnt_q;
  logic                        initDone_q;
  logic                        gazeChanged_q;
  logic                        axLevelEn_q;
  logic [AX_LEVEL_WIDTH-1:0]   axLevelData_q;
  logic                        psw0Prev_q;

  logic                        initPhase;
  logic [SW_WIDTH-1:0]         swStable;
  logic [SW_WIDTH-1:0]         swFlip;
  logic [PSW_WIDTH-1:0]        pswStable;
  logic [PSW_WIDTH-1:0]        pswFlip;
  logic                        pressDet;
  logic [AX_LEVEL_WIDTH-1:0]   capData;
  logic                        unusedPsw;

  assign initPhase = state_q == SCS_INIT;

  for (genvar g = 0; g < SW_WIDTH; g++) begin : g_sw
    switch_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .negResetIn(negResetIn),
      .init      (initPhase),
      .in        (swIn[g]),
      .stable    (swStable[g]),
      .flip      (swFlip[g])
    );
  end

  for (genvar g = 0; g < PSW_WIDTH; g++) begin : g_psw
    switch_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .negResetIn(negResetIn),
      .init      (initPhase),
      .in        (pswIn[g]),
      .stable    (pswStable[g]),
      .flip      (pswFlip[g])
    );
  end

  assign unusedPsw = ^{pswFlip, pswStable};

  // Press = stable psw[0] rose on the previous edge.
  assign pressDet = pswStable[0] & ~psw0Prev_q;
  assign capData  = {pswStable[AX_LEVEL_WIDTH-2:1], 2'b00};

  always_ff @(posedge clk or negedge negResetIn) begin
    if (!negResetIn) begin
      state_q       <= SCS_INIT;
      initCnt_q     <= '0;
      initDone_q    <= 1'b0;
      gazeChanged_q <= 1'b0;
      axLevelEn_q   <= 1'b0;
      axLevelData_q <= '0;
      psw0Prev_q    <= 1'b0;
    end else begin
      psw0Prev_q    <= pswStable[0];
      gazeChanged_q <= 1'b0;
      axLevelEn_q   <= 1'b0;
      case (state_q)
        SCS_INIT: begin
          if (initCnt_q == INIT_LAST) begin
            state_q    <= SCS_RUN;
            initDone_q <= 1'b1;
          end else begin
            initCnt_q <= initCnt_q + CW'(1);
          end
        end
        SCS_RUN: begin
          gazeChanged_q <= |swFlip;
          if (pressDet) begin
            axLevelEn_q   <= 1'b1;
            axLevelData_q <= capData;
          end
        end
        default: state_q <= SCS_INIT;
      endcase
    end
  end

  assign gazeOut     = swStable;
  assign gazeChanged = gazeChanged_q;
  assign axLevelEn   = axLevelEn_q;
  assign axLevelData = axLevelData_q;
  assign initDone    = initDone_q;

endmodule
